// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: access size codes, FSM states and port ids.
// Pure declarations; no logic, no latency, no flow control.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUS_IF = 2'b01,
        ST_BUS_LS = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables, replicated store data, misalignment flag and load extraction.
// Purely combinational (zero latency); no flow control of its own.
module lsu_lane_align
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        mis_o,
    input  logic [1:0]  rsp_size_i,
    input  logic        rsp_sext_i,
    input  logic [1:0]  rsp_off_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = req_wdata_i;
        mis_o   = 1'b0;
        case (req_size_i)
            SZ_B: begin
                be_o    = 4'b0001 << req_off_i;
                wdata_o = {4{req_wdata_i[7:0]}};
            end
            SZ_H: begin
                be_o    = 4'b0011 << req_off_i;
                wdata_o = {2{req_wdata_i[15:0]}};
                mis_o   = req_off_i[0];
            end
            SZ_W: begin
                be_o  = 4'b1111;
                mis_o = |req_off_i;
            end
            // The reserved size code never reaches the bus.
            default: mis_o = 1'b1;
        endcase
    end

    assign shifted = rsp_rdata_i >> {rsp_off_i, 3'b000};

    always_comb begin
        rdata_o = shifted;
        case (rsp_size_i)
            SZ_B:    rdata_o = {{24{rsp_sext_i & shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_o = {{16{rsp_sext_i & shifted[15]}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin share of one memory bus between fetch and load/store; 4 cycles req->done on a zero-wait bus, 2 if misaligned.
// Requesters hold req until their done pulse; the bus holds m_req until m_ack/m_err or the timeout expires.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TO_CYC = 255,
    parameter int TO_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    output logic        if_mis,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_sext,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic        ls_err,
    output logic        ls_mis,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic        m_err,
    input  logic [31:0] m_rdata
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    state_e          state_q, state_d;
    port_e           port_q, port_d, last_q, last_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [1:0]      size_q, off_q;
    logic            sext_q, m_we_q;
    logic [31:0]     m_addr_q, m_wdata_q;
    logic [3:0]      m_be_q;
    logic [31:0]     if_rdata_q, ls_rdata_q;
    logic            if_err_q, if_mis_q, ls_err_q, ls_mis_q;

    logic            sel_ls, grant, bus_fin, bus_fail, g_mis;
    logic [1:0]      g_size;
    logic [31:0]     g_addr, g_wdata, ld_data;
    logic [3:0]      g_be;

    // On contention, the port that did not win last time gets the bus.
    assign sel_ls = ls_req & (~if_req | (last_q == PORT_IF));
    assign g_size = sel_ls ? ls_size : SZ_W;
    assign g_addr = sel_ls ? ls_addr : if_addr;

    lsu_lane_align u_align (
        .req_size_i  (g_size),
        .req_off_i   (g_addr[1:0]),
        .req_wdata_i (ls_wdata),
        .be_o        (g_be),
        .wdata_o     (g_wdata),
        .mis_o       (g_mis),
        .rsp_size_i  (size_q),
        .rsp_sext_i  (sext_q),
        .rsp_off_i   (off_q),
        .rsp_rdata_i (m_rdata),
        .rdata_o     (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        grant    = 1'b0;
        bus_fin  = 1'b0;
        bus_fail = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req | ls_req) begin
                    grant   = 1'b1;
                    port_d  = sel_ls ? PORT_LS : PORT_IF;
                    last_d  = port_d;
                    state_d = g_mis ? ST_RESP : (sel_ls ? ST_BUS_LS : ST_BUS_IF);
                end
            end
            ST_BUS_IF, ST_BUS_LS: begin
                if (m_err) begin
                    bus_fin  = 1'b1;
                    bus_fail = 1'b1;
                end else if (m_ack) begin
                    bus_fin = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    bus_fin  = 1'b1;
                    bus_fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
                if (bus_fin) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            port_q     <= PORT_IF;
            last_q     <= PORT_IF;
            cnt_q      <= '0;
            size_q     <= SZ_B;
            off_q      <= 2'b00;
            sext_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_be_q     <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            if_err_q   <= 1'b0;
            if_mis_q   <= 1'b0;
            ls_rdata_q <= '0;
            ls_err_q   <= 1'b0;
            ls_mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            if (grant && !g_mis) begin
                m_we_q    <= sel_ls & ls_we;
                m_addr_q  <= {g_addr[31:2], 2'b00};
                m_be_q    <= g_be;
                m_wdata_q <= g_wdata;
                size_q    <= g_size;
                sext_q    <= sel_ls & ls_sext;
                off_q     <= g_addr[1:0];
            end
            if (grant && g_mis) begin
                if (sel_ls) begin
                    ls_mis_q <= 1'b1;
                    ls_err_q <= 1'b0;
                end else begin
                    if_mis_q <= 1'b1;
                    if_err_q <= 1'b0;
                end
            end
            // Status lands on the edge into RESP so it is valid with done and held afterwards.
            if (bus_fin) begin
                if (port_q == PORT_LS) begin
                    ls_mis_q <= 1'b0;
                    ls_err_q <= bus_fail;
                    if (!bus_fail && !m_we_q) ls_rdata_q <= ld_data;
                end else begin
                    if_mis_q <= 1'b0;
                    if_err_q <= bus_fail;
                    if (!bus_fail) if_rdata_q <= ld_data;
                end
            end
        end
    end

    assign m_req    = (state_q == ST_BUS_IF) || (state_q == ST_BUS_LS);
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_be     = m_be_q;
    assign m_wdata  = m_wdata_q;
    assign if_done  = (state_q == ST_RESP) && (port_q == PORT_IF);
    assign ls_done  = (state_q == ST_RESP) && (port_q == PORT_LS);
    assign if_rdata = if_rdata_q;
    assign if_err   = if_err_q;
    assign if_mis   = if_mis_q;
    assign ls_rdata = ls_rdata_q;
    assign ls_err   = ls_err_q;
    assign ls_mis   = ls_mis_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a spec-level model and a per-cycle compare process.
module tb_mem_bus_arbiter;

    localparam int TO       = 8;
    localparam int MODE_OK  = 0;
    localparam int MODE_ERR = 1;
    localparam int MODE_TO  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, ls_sext = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, m_rdata = '0;
    logic [1:0]  ls_size = 2'b10;
    logic        m_ack = 1'b0, m_err = 1'b0;
    logic [31:0] if_rdata, ls_rdata, m_addr, m_wdata;
    logic        if_done, if_err, if_mis, ls_done, ls_err, ls_mis, m_req, m_we;
    logic [3:0]  m_be;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    bit in_run = 1'b0;

    // Model state: last grantee (0 = fetch, 1 = load/store) and expected outputs.
    bit          rr_last = 1'b0;
    bit          exp_port, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    int          exp_edges, exp_mreq;
    logic [31:0] exp_if_rdata = '0, exp_ls_rdata = '0;
    bit          exp_if_err = 0, exp_if_mis = 0, exp_ls_err = 0, exp_ls_mis = 0;
    logic [3:0]  seen_be;
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_we;
    logic [2:0]  grants;

    mem_bus_arbiter #(.TO_CYC(TO), .TO_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_err(if_err), .if_mis(if_mis),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_sext(ls_sext),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
        .ls_done(ls_done), .ls_err(ls_err), .ls_mis(ls_mis),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, want);
    endtask

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // Gather the addressed bytes from the bus word, then widen.
    function automatic logic [31:0] model_load(input int n, input bit sext, input int off,
                                               input logic [31:0] bus);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = bus[8*(off+k) +: 8];
        if (sext && n < 4 && v[8*n-1]) begin
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic predict(input int mode, input int waits, input logic [31:0] rbus);
        bit g, mis, sx;
        logic [1:0] sz;
        logic [31:0] ad;
        int n, off;
        g = ls_req && (!if_req || rr_last == 1'b0);
        rr_last = g;
        sz  = g ? ls_size : 2'b10;
        ad  = g ? ls_addr : if_addr;
        sx  = g && ls_sext;
        n   = nbytes(sz);
        off = int'(ad[1:0]);
        mis = (n == 0) || ((off % n) != 0);
        exp_port  = g;
        exp_addr  = {ad[31:2], 2'b00};
        exp_we    = g && ls_we;
        exp_be    = 4'b0000;
        exp_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (n > 0) begin
                exp_be[i] = (i >= off) && (i < off + n);
                exp_wdata[8*i +: 8] = ls_wdata[8*(i % n) +: 8];
            end
        end
        if (mis) begin
            exp_edges = 1; exp_mreq = 0;
            if (g) begin exp_ls_mis = 1; exp_ls_err = 0; end
            else   begin exp_if_mis = 1; exp_if_err = 0; end
        end else if (mode == MODE_TO) begin
            exp_edges = TO + 1; exp_mreq = TO;
            if (g) begin exp_ls_mis = 0; exp_ls_err = 1; end
            else   begin exp_if_mis = 0; exp_if_err = 1; end
        end else begin
            exp_edges = 3 + waits; exp_mreq = 2 + waits;
            if (g) begin exp_ls_mis = 0; exp_ls_err = (mode == MODE_ERR); end
            else   begin exp_if_mis = 0; exp_if_err = (mode == MODE_ERR); end
            if (mode == MODE_OK && !exp_we) begin
                if (g) exp_ls_rdata = model_load(n, sx, off, rbus);
                else   exp_if_rdata = model_load(4, 1'b0, 0, rbus);
            end
        end
    endtask

    // Bus slave acks 'waits' cycles after the zero-wait slot; drops the grantee's req on done if asked.
    task automatic run(input int mode, input int waits, input logic [31:0] rbus, input bit drop);
        int edges = 0;
        int mreq = 0;
        int d0 = done_cnt;
        bit got = 1'b0;
        predict(mode, waits, rbus);
        in_run = 1'b1;
        while (!got && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            m_ack = 1'b0; m_err = 1'b0; m_rdata = $urandom;
            if (m_req) begin
                mreq++;
                seen_be = m_be; seen_addr = m_addr; seen_wdata = m_wdata; seen_we = m_we;
                if (mode != MODE_TO && mreq == waits + 2) begin
                    m_ack = 1'b1; m_err = (mode == MODE_ERR); m_rdata = rbus;
                end
            end
            if (if_done || ls_done) begin
                got = 1'b1;
                if (drop) begin
                    if (exp_port) ls_req = 1'b0;
                    else          if_req = 1'b0;
                end
            end
        end
        chk("done_seen", got, 1);
        chk("latency", edges, exp_edges);
        chk("m_req_cycles", mreq, exp_mreq);
        @(negedge clk); #1;
        chk("done_pulses", done_cnt - d0, 1);
        in_run = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", if_done | ls_done, 0);
        chk("if_hold", {if_rdata[30:0], if_err, if_mis} ^ {exp_if_rdata[30:0], exp_if_err, exp_if_mis}, 0);
        chk("ls_hold", {ls_rdata[30:0], ls_err, ls_mis} ^ {exp_ls_rdata[30:0], exp_ls_err, exp_ls_mis}, 0);
        grants = {grants[1:0], exp_port};
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; m_ack = 1'b0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rr_last = 1'b0;
        exp_if_rdata = '0; exp_ls_rdata = '0;
        exp_if_err = 0; exp_if_mis = 0; exp_ls_err = 0; exp_ls_mis = 0;
    endtask

    task automatic set_ls(input bit we, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] d);
        ls_we = we; ls_size = sz; ls_sext = sx; ls_addr = a; ls_wdata = d; ls_req = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m_req) begin
                chk("m_addr", m_addr, exp_addr);
                chk("m_be", m_be, exp_be);
                chk("m_we", m_we, exp_we);
                if (exp_we) chk("m_wdata", m_wdata, exp_wdata);
            end
            if (if_done) begin
                chk("if_done_owner", in_run && !exp_port, 1);
                chk("if_rdata", if_rdata, exp_if_rdata);
                chk("if_err", if_err, exp_if_err);
                chk("if_mis", if_mis, exp_if_mis);
                chk("if_err_mis_excl", if_err & if_mis, 0);
                done_cnt++;
            end
            if (ls_done) begin
                chk("ls_done_owner", in_run && exp_port, 1);
                chk("ls_rdata", ls_rdata, exp_ls_rdata);
                chk("ls_err", ls_err, exp_ls_err);
                chk("ls_mis", ls_mis, exp_ls_mis);
                chk("ls_err_mis_excl", ls_err & ls_mis, 0);
                done_cnt++;
            end
        end
    end

    initial begin
        int seen, d0;
        do_reset();
        chk("reset_ctl", {m_req, m_we, m_be, if_done, ls_done, if_err, if_mis, ls_err, ls_mis}, 0);
        chk("reset_addr", m_addr, 0);
        chk("reset_wdata", m_wdata, 0);
        chk("reset_rdata", if_rdata | ls_rdata, 0);

        if_addr = 32'h100; if_req = 1'b1;
        run(MODE_OK, 2, 32'hDEADBEEF, 1);
        chk("fetch_rdata_lit", if_rdata, 32'hDEADBEEF);
        chk("fetch_addr_lit", seen_addr, 32'h100);
        chk("fetch_be_lit", seen_be, 4'hF);
        chk("fetch_err_lit", if_err, 0);

        set_ls(0, 2'b00, 1, 32'h203, 0);
        run(MODE_OK, 0, 32'h80123456, 1);
        chk("lb_sext_lit", ls_rdata, 32'hFFFFFF80);
        chk("lb_addr_lit", seen_addr, 32'h200);
        set_ls(0, 2'b00, 0, 32'h203, 0);
        run(MODE_OK, 0, 32'h80123456, 1);
        chk("lbu_lit", ls_rdata, 32'h00000080);

        set_ls(1, 2'b01, 0, 32'h102, 32'h1234ABCD);
        run(MODE_OK, 1, 32'h0, 1);
        chk("sh_be_lit", seen_be, 4'b1100);
        chk("sh_wdata_lit", seen_wdata, 32'hABCDABCD);
        chk("sh_we_lit", seen_we, 1);

        set_ls(1, 2'b10, 0, 32'h101, 32'h55);
        run(MODE_OK, 0, 32'h0, 1);
        chk("sw_mis_lit", {ls_mis, ls_err}, 2'b10);

        set_ls(0, 2'b01, 1, 32'h202, 0);
        run(MODE_OK, 3, 32'h80017777, 1);
        chk("lh_sext_lit", ls_rdata, 32'hFFFF8001);
        set_ls(1, 2'b00, 0, 32'h001, 32'h5A);
        run(MODE_OK, 0, 32'h0, 1);
        set_ls(0, 2'b11, 0, 32'h200, 0);
        run(MODE_OK, 0, 32'h0, 1);
        set_ls(0, 2'b01, 0, 32'h101, 0);
        run(MODE_OK, 0, 32'h0, 1);

        set_ls(0, 2'b10, 0, 32'h300, 0);
        run(MODE_TO, 0, 32'h0, 1);
        chk("timeout_err_lit", {ls_err, ls_mis}, 2'b10);
        set_ls(0, 2'b10, 0, 32'h304, 0);
        run(MODE_ERR, 1, 32'h11111111, 1);
        chk("err_ack_lit", ls_err, 1);
        chk("err_keeps_rdata_lit", ls_rdata, 32'hFFFF8001);

        if_addr = 32'h102; if_req = 1'b1;
        run(MODE_OK, 0, 32'h0, 1);
        chk("fetch_mis_lit", {if_mis, if_err}, 2'b10);
        if_addr = 32'h104; if_req = 1'b1;
        run(MODE_ERR, 0, 32'h0, 1);
        chk("fetch_err_keeps_rdata_lit", if_rdata, 32'hDEADBEEF);
        set_ls(0, 2'b01, 0, 32'h200, 0);
        run(MODE_OK, 0, 32'hAAAA8123, 1);
        chk("lhu_lit", ls_rdata, 32'h00008123);

        // Contention straight out of reset: both ports held high across three grants.
        do_reset();
        if_addr = 32'h600; if_req = 1'b1;
        set_ls(0, 2'b10, 0, 32'h700, 0);
        run(MODE_OK, 0, 32'h01020304, 0);
        run(MODE_OK, 1, 32'hA5A5A5A5, 0);
        run(MODE_OK, 0, 32'h0BADF00D, 0);
        if_req = 1'b0; ls_req = 1'b0;
        chk("rr_order_lit", grants, 3'b101);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (m_req) seen++;
        end
        chk("no_regrant", seen, 0);

        do_reset();
        set_ls(0, 2'b10, 0, 32'h400, 0);
        predict(MODE_TO, 0, 32'h0);
        seen = 0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            @(posedge clk); #1;
            if (m_req) seen++;
        end
        chk("rst_mid_bus_started", seen, 2);
        d0 = done_cnt;
        rst = 1'b1; ls_req = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_m_req", m_req, 0);
        rst = 1'b0;
        rr_last = 1'b0;
        exp_ls_err = 0; exp_ls_mis = 0; exp_ls_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_no_done", done_cnt - d0, 0);
        chk("rst_mid_status", {ls_done, ls_err, ls_mis, m_req}, 0);
        if_addr = 32'h500; if_req = 1'b1;
        run(MODE_OK, 0, 32'hCAFEF00D, 1);
        chk("post_rst_fetch_lit", if_rdata, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
